// File: rtl/done_tracker_pkg.sv
// Shared types and width helpers for the done_tracker iteration-completion tracker.
package done_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Index width for an n-channel vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/done_tracker_at_most_one_hot.sv
// Combinational at-most-one-hot checker and binary encoder for an N-bit candidate vector.
module at_most_one_hot
  import done_tracker_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    flags,
  output logic            qualifying,
  output logic            exactly_one,
  output logic [IDXW-1:0] idx
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  // OR-encoding is exact for a one-hot vector; the index is ignored otherwise.
  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (flags[i]) begin
        cnt = cnt + CW'(1);
        idx = idx | IDXW'(i);
      end
    end
  end

  assign qualifying  = (cnt <= CW'(1));
  assign exactly_one = (cnt == CW'(1));

endmodule

// File: rtl/done_tracker.sv
// Iteration-completion tracker: detects a stable at-most-one-hot candidate vector and latches the winner.
// Optional iteration-limit timeout is compiled in with `define DONE_TRACKER_TIMEOUT_EN.
//
// state      | meaning
// ST_IDLE    | waiting for start, step ignored
// ST_RUN     | accepting steps, tracking stability
// ST_DONE    | completion reached, results held
// ST_TIMEOUT | iteration limit reached without completion
module done_tracker
  import done_tracker_pkg::*;
#(
  parameter int N        = 4,
  parameter int STABLE   = 2,
  parameter int ITERW    = 16,
  parameter int MAX_ITER = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic [N-1:0]         flags,
  output logic                 busy,
  output logic                 done,
  output logic                 winner_valid,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic [ITERW-1:0]     iter_cnt,
  output logic                 timeout
);

  localparam int IDXW = idx_width(N);
  localparam int SW   = $clog2(STABLE + 1);
  localparam logic [SW-1:0]    STABLE_C = SW'(STABLE);
  localparam logic [ITERW-1:0] MAX_C    = ITERW'(MAX_ITER);

  state_t            state, state_nx;
  logic [ITERW-1:0]  iter_q, iter_nx, iter_inc;
  logic [SW-1:0]     stab_q, stab_nx;
  logic [N-1:0]      pat_q, pat_nx;
  logic              wv_q, wv_nx;
  logic [IDXW-1:0]   wi_q, wi_nx;

  logic              qual;
  logic              one;
  logic [IDXW-1:0]   enc;

  at_most_one_hot #(.N(N), .IDXW(IDXW)) u_check (
    .flags       (flags),
    .qualifying  (qual),
    .exactly_one (one),
    .idx         (enc)
  );

  assign iter_inc = (&iter_q) ? iter_q : iter_q + ITERW'(1);

  always_comb begin
    state_nx = state;
    iter_nx  = iter_q;
    stab_nx  = stab_q;
    pat_nx   = pat_q;
    wv_nx    = wv_q;
    wi_nx    = wi_q;
    if (start) begin
      state_nx = ST_RUN;
      iter_nx  = '0;
      stab_nx  = '0;
      pat_nx   = '0;
      wv_nx    = 1'b0;
      wi_nx    = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (step) begin
            iter_nx = iter_inc;
            if (!qual) begin
              stab_nx = '0;
            end else if (flags == pat_q) begin
              // stab_q stays below STABLE in RUN, so this cannot overflow
              stab_nx = stab_q + SW'(1);
            end else begin
              stab_nx = SW'(1);
              pat_nx  = flags;
            end
            if (qual && (stab_nx == STABLE_C)) begin
              state_nx = ST_DONE;
              wv_nx    = one;
              wi_nx    = one ? enc : '0;
            end
`ifdef DONE_TRACKER_TIMEOUT_EN
            else if (iter_inc == MAX_C) begin
              state_nx = ST_TIMEOUT;
            end
`endif
          end
        end
        ST_IDLE, ST_DONE: ;
`ifdef DONE_TRACKER_TIMEOUT_EN
        ST_TIMEOUT: ;
`endif
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      iter_q <= '0;
      stab_q <= '0;
      pat_q  <= '0;
      wv_q   <= 1'b0;
      wi_q   <= '0;
    end else begin
      state  <= state_nx;
      iter_q <= iter_nx;
      stab_q <= stab_nx;
      pat_q  <= pat_nx;
      wv_q   <= wv_nx;
      wi_q   <= wi_nx;
    end
  end

  assign busy         = (state == ST_RUN);
  assign done         = (state == ST_DONE);
  assign winner_valid = wv_q;
  assign winner_idx   = wi_q;
  assign iter_cnt     = iter_q;

`ifdef DONE_TRACKER_TIMEOUT_EN
  assign timeout = (state == ST_TIMEOUT);
`else
  logic unused_limit;
  assign unused_limit = ^MAX_C;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_done_tracker.sv
// Scoreboard bench for done_tracker: history-based reference model, queued expectations, cycle monitor.
module tb_done_tracker;

  localparam int N        = 4;
  localparam int STABLE   = 2;
  localparam int ITERW    = 16;
  localparam int MAX_ITER = 8;
`ifdef DONE_TRACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, start = 1'b0, step = 1'b0;
  logic [N-1:0]     flags = '0;
  logic             busy, done, winner_valid, timeout;
  logic [1:0]       winner_idx;
  logic [ITERW-1:0] iter_cnt;

  logic             rst7 = 1'b1, start7 = 1'b0, step7 = 1'b0;
  logic [6:0]       flags7 = '0;
  logic             busy7, done7, wv7, to7;
  logic [2:0]       wi7;
  logic [ITERW-1:0] iter7;

  done_tracker #(.N(N), .STABLE(STABLE), .ITERW(ITERW), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .flags(flags),
    .busy(busy), .done(done), .winner_valid(winner_valid), .winner_idx(winner_idx),
    .iter_cnt(iter_cnt), .timeout(timeout)
  );

  done_tracker #(.N(7), .STABLE(1), .ITERW(ITERW), .MAX_ITER(64)) dut7 (
    .clk(clk), .rst(rst7), .start(start7), .step(step7), .flags(flags7),
    .busy(busy7), .done(done7), .winner_valid(wv7), .winner_idx(wi7),
    .iter_cnt(iter7), .timeout(to7)
  );

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             wv;
    logic [1:0]       wi;
    logic [ITERW-1:0] iter;
    logic             to;
  } obs_t;

  obs_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 run, 2 done, 3 timeout; history of accepted vectors this run.
  int         mode = 0;
  int         m_iter = 0;
  logic       m_wv = 1'b0;
  int         m_wi = 0;
  logic [N-1:0] hist[$];

  function automatic int trailing_run();
    int k = 0;
    logic [N-1:0] last;
    last = hist[hist.size()-1];
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == last && $countones(hist[i]) <= 1) k++;
      else break;
    end
    return k;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic st, input logic [N-1:0] f);
    if (r || s) begin
      mode = r ? 0 : 1;
      m_iter = 0; m_wv = 1'b0; m_wi = 0;
      hist.delete();
    end else if (mode == 1 && st) begin
      hist.push_back(f);
      if (m_iter < (1 << ITERW) - 1) m_iter++;
      if ($countones(f) <= 1 && trailing_run() >= STABLE) begin
        mode = 2;
        m_wv = ($countones(f) == 1);
        m_wi = 0;
        for (int i = 0; i < N; i++) if (f[i]) m_wi = i;
      end else if (TO_EN && m_iter == MAX_ITER) begin
        mode = 3;
      end
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic st, input logic [N-1:0] f);
    obs_t e;
    rst = r; start = s; step = st; flags = f;
    model_step(r, s, st, f);
    e.busy = (mode == 1);
    e.done = (mode == 2);
    e.wv   = m_wv;
    e.wi   = 2'(m_wi);
    e.iter = ITERW'(m_iter);
    e.to   = (mode == 3);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input logic [N-1:0] f, input int count);
    for (int i = 0; i < count; i++) drive(1'b0, 1'b0, 1'b1, f);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: one registered observation per cycle, compared against the queued expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL obs_underflow at %0t: no expectation queued", $time);
      end else begin
        e = exp_q.pop_front();
        a = '{busy, done, winner_valid, winner_idx, iter_cnt, timeout};
        if (a !== e) begin
          n_bad++;
          $display("FAIL obs at %0t: got busy=%b done=%b wv=%b idx=%0d iter=%0d to=%b, expected busy=%b done=%b wv=%b idx=%0d iter=%0d to=%b",
                   $time, a.busy, a.done, a.wv, a.wi, a.iter, a.to,
                   e.busy, e.done, e.wv, e.wi, e.iter, e.to);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] f;
    drive(1, 0, 0, '0); drive(1, 0, 0, '0); drive(0, 0, 0, '0);

    drive(0, 1, 0, '0); steps(4'b1100, 3);                 // reset mid-run
    drive(1, 1, 0, '0); drive(0, 0, 0, '0);
    drive(0, 1, 0, '0); steps(4'b0100, 2); drive(0, 0, 0, '0);

    drive(0, 1, 0, '0);                                    // one-hot completion
    steps(4'b1011, 1); steps(4'b0100, 2); drive(0, 0, 0, '0);
    steps(4'b0001, 2); drive(0, 0, 0, '0);                 // step in DONE ignored

    drive(0, 1, 0, '0); steps(4'b0100, 1); steps(4'b0001, 2);
    drive(0, 1, 0, '0); steps(4'b0000, 2); drive(0, 0, 0, '0);

    drive(0, 1, 0, '0); steps(4'b1100, 8); drive(0, 0, 0, '0);
    drive(0, 1, 1, 4'b0100); drive(0, 0, 0, '0);           // start beats step
    steps(4'b1100, 1); drive(0, 1, 1, 4'b0100); drive(0, 0, 0, '0);

    drive(0, 1, 0, '0); steps(4'b1100, 6); steps(4'b0010, 2); drive(0, 0, 0, '0);
    drive(0, 1, 0, '0); steps(4'b1100, 20); drive(0, 0, 1, 4'b1000);

    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 3))
        0: f = '0;
        1, 2: f = 4'(1 << $urandom_range(0, N - 1));
        default: f = 4'($urandom_range(0, 15));
      endcase
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) != 0), f);
    end

    // N=7, STABLE=1 instance: top channel wins on a single step.
    rst7 = 1'b0; drive(0, 0, 0, '0);
    start7 = 1'b1; drive(0, 0, 0, '0); start7 = 1'b0;
    chk("n7_busy_after_start", busy7, 1);
    chk("n7_done_after_start", done7, 0);
    step7 = 1'b1; flags7 = 7'b1000000; drive(0, 0, 0, '0); step7 = 1'b0;
    chk("n7_done", done7, 1);
    chk("n7_winner_valid", wv7, 1);
    chk("n7_winner_idx", wi7, 6);
    chk("n7_iter", iter7, 1);
    chk("n7_busy_fall", busy7, 0);
    chk("n7_timeout", to7, 0);
    step7 = 1'b1; flags7 = 7'b0000001; drive(0, 0, 0, '0); step7 = 1'b0;
    drive(0, 0, 0, '0);
    chk("n7_hold_idx", wi7, 6);
    chk("n7_hold_iter", iter7, 1);
    chk("n7_hold_done", done7, 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/done_tracker.md
# done_tracker

Parametrised iteration-completion tracker for the comparator/max-finder datapath. It watches an N-bit vector of per-channel "still a candidate" flags once per datapath iteration. It declares completion when that vector has been at-most-one-hot, with an unchanged pattern, for a configurable number of consecutive iterations. It then latches the surviving channel index, holds `done` until the controller restarts it, and optionally flags a timeout.

## Interface
- `N`, 4, number of candidate channels (≥ 2)
- `STABLE`, 2, consecutive qualifying iterations required for completion (≥ 1)
- `ITERW`, 16, width of the iteration counter
- `MAX_ITER`, 64, iteration limit; used only when `DONE_TRACKER_TIMEOUT_EN` is defined (1 … 2^ITERW−1)
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins or restarts a run
- `step`  in  1  one iteration result is valid on `flags` this cycle
- `flags`  in  N  per-channel candidate flags
- `busy`  out  1  high while in RUN
- `done`  out  1  level; high in DONE
- `winner_valid`  out  1  at completion: 1 if exactly one flag was set, 0 if none were set
- `winner_idx`  out  $clog2(N)  index of the set flag at completion; 0 when `winner_valid`=0
- `iter_cnt`  out  ITERW  steps accepted in the current run; saturates at all-ones
- `timeout`  out  1  high in TIMEOUT; constant 0 when the feature is compiled out

## Operation
- A flag vector is **qualifying** when at most one bit is set (all-zero counts).
- States are IDLE, RUN, DONE and TIMEOUT. Reset puts the block in IDLE.
- **IDLE**
  - `start` → RUN. Clears `iter_cnt`, the stable counter, the stored pattern, and all result outputs.
  - `step` is ignored.
- **RUN**, on `step`=1:
  - `iter_cnt` increments, saturating at all-ones.
  - Non-qualifying vector: stable counter ← 0.
  - Qualifying vector equal to the stored pattern: stable counter +1.
  - Qualifying vector different from the stored pattern: stable counter ← 1 and stored pattern ← `flags`.
  - When the updated stable counter equals `STABLE`: go to DONE and latch `winner_valid` and `winner_idx` from this `flags`.
  - With `STABLE`=1, the first qualifying step completes the run.
- **RUN**, on `step`=0: all state holds.
- **DONE**: outputs hold. `step` is ignored. `start` → RUN with a full clear.
- **TIMEOUT** (feature compiled in only): entered from RUN when an accepted step brings `iter_cnt` to `MAX_ITER` without completing. `timeout`=1, `done`=0, result outputs are 0. `start` → RUN.
- **Priorities**
  - `start` beats `step` in any state. `start` in RUN restarts the run, and a `step` in the same cycle is discarded.
  - If completion and the timeout limit fall on the same step, completion wins.
- **Reset** in any state, including mid-run, returns to IDLE in the next cycle. It wins over `start`.

## Timing
- Every output is registered. Reset value of every output is 0.
- `done`, `winner_*` and `timeout` rise on the clock edge after the completing or limiting `step` is sampled (latency 1).
- `busy` rises 1 cycle after `start` and falls in the same cycle that `done` or `timeout` rises.
- `iter_cnt` is valid 1 cycle after each accepted step.
- Minimum run: `start` at cycle 0, then qualifying steps at cycles 1 … STABLE, gives `done`=1 at cycle STABLE+1.
- The block imposes no back-pressure; `step` may be asserted every cycle.

## Configuration
- `DONE_TRACKER_TIMEOUT_EN`
  - Defined: the iteration limit is checked and TIMEOUT is reachable.
  - Undefined: TIMEOUT state and limit comparator are absent, `timeout` is tied to 0, and RUN continues indefinitely until completion or `start`.

## Structure
- Shared package `done_tracker_pkg` holds:
  - the state enum (IDLE/RUN/DONE/TIMEOUT)
  - `IDXW`, derived as `$clog2(N)`, as a function/localparam helper
- One combinational sub-module, `at_most_one_hot`, parametrised by `N`:
  - outputs `qualifying`, `exactly_one` and the encoded index
  - it is the generalised replacement for the fixed 4-input checker and encoder
- The top level contains the FSM, stable counter, stored pattern, iteration counter and result registers.

## Test plan
Unless stated, N=4, STABLE=2, MAX_ITER=8, feature compiled in.
- Reset mid-run: `rst` after 3 steps → next cycle IDLE, all outputs 0, and a later `start` runs normally.
- One-hot completion: `start`, then steps with 1011, 0100, 0100 → `done`=1, `winner_valid`=1, `winner_idx`=2, `iter_cnt`=3.
- Pattern change: steps 0100, 0001, 0001 → completion on the third step with `winner_idx`=0, not on the second. All-zero completion: steps 0000, 0000 → `done`=1, `winner_valid`=0.
- Timeout: 8 steps of 1100 → `timeout`=1, `done`=0, `busy`=0. Then `start` and `step` in the same cycle → RUN with `iter_cnt`=0.
- Completion on the limit: 6×1100 then 0010, 0010 (step 8) → `done`=1, `timeout`=0. Compiled out: 20×1100 → `busy` stays 1, `timeout`=0.
- Width: N=7, STABLE=1, single step 1000000 → `winner_idx`=6 one cycle later. `step` while in DONE changes nothing.
